// File: rtl/seg_pkg.sv
// Shared segment codes, digit table and FSM state encoding for the binary-to-7-segment converter.
// Codes are active-low: bit7 = decimal point, bits 6:0 = segments g..a.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK   = 8'hFF;
    localparam logic [7:0] SEG_DASH    = 8'hBF;
    localparam logic [7:0] SEG_DP_MASK = 8'h7F;

    localparam int NUM_DIGITS = 6;
    localparam int BCD_W      = 4 * NUM_DIGITS;

    // Index n holds the code for nibble value n (0-9 decimal, A-F hex).
    localparam logic [15:0][7:0] SEG_DIGIT_TABLE = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    // state  | meaning
    // IDLE   | waiting for load, outputs hold last result
    // SHIFT  | one double-dabble step per cycle, BIN_W cycles
    // ENCODE | register digit codes, pulse done
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_ENCODE = 2'd2
    } state_t;

    function automatic logic [3:0] bcd_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational nibble-to-segment encoder with blank, dash and decimal-point overrides.
module seg7_encode
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    input  logic       i_dash,
    input  logic       i_dp,
    output logic [7:0] o_code
);

    logic [7:0] w_base;

    always_comb begin
        if (i_dash)
            w_base = SEG_DASH;
        else if (i_blank)
            w_base = SEG_BLANK;
        else
            w_base = SEG_DIGIT_TABLE[i_nibble];
        // The dash display never carries a decimal point.
        o_code = (i_dp && !i_dash) ? (w_base & SEG_DP_MASK) : w_base;
    end

endmodule

// File: rtl/seg_bin_to_digits.sv
// Sequential binary-to-six-digit 7-segment converter (shift-add-3) with load/busy/done handshake.
// Optional macro SEG_HEX_MODE_EN adds i_hex_mode for six-nibble hexadecimal display.
module seg_bin_to_digits
    import seg_pkg::*;
#(
    parameter int          BIN_W   = 20,
    parameter int unsigned MAX_VAL = 999999
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [BIN_W-1:0] i_bin_in,
    input  logic [2:0]       i_dp_pos,
`ifdef SEG_HEX_MODE_EN
    input  logic             i_hex_mode,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic             o_overflow,
    output logic [7:0]       o_seg_data_0,
    output logic [7:0]       o_seg_data_1,
    output logic [7:0]       o_seg_data_2,
    output logic [7:0]       o_seg_data_3,
    output logic [7:0]       o_seg_data_4,
    output logic [7:0]       o_seg_data_5
);

    localparam int                CNT_W    = $clog2(BIN_W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BIN_W - 1);

    state_t             r_state;
    logic [BCD_W-1:0]   r_bcd;
    logic [BIN_W-1:0]   r_bin;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_dp;
    logic               r_ovf_pend;
    logic               r_busy;
    logic               r_done;
    logic               r_overflow;
    logic [7:0]         r_seg [NUM_DIGITS];

    logic [BCD_W-1:0]   w_bcd_adj;
    logic [BCD_W-1:0]   w_digits;
    logic               w_over;
    logic               w_ovf_cap;
    logic [NUM_DIGITS-1:0] w_blank;
    logic [NUM_DIGITS-1:0] w_dp_sel;
    logic [7:0]         w_code [NUM_DIGITS];

    assign w_over = 64'(i_bin_in) > 64'(MAX_VAL);

`ifdef SEG_HEX_MODE_EN
    logic               r_hex;
    logic [BCD_W-1:0]   r_hex_val;
    logic [63:0]        w_bin_ext;

    assign w_bin_ext = 64'(i_bin_in);
    assign w_ovf_cap = i_hex_mode ? 1'b0 : w_over;
    assign w_digits  = r_hex ? r_hex_val : r_bcd;
`else
    assign w_ovf_cap = w_over;
    assign w_digits  = r_bcd;
`endif

    always_comb begin
        w_bcd_adj = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            w_bcd_adj[i*4 +: 4] = bcd_adjust(r_bcd[i*4 +: 4]);
    end

    // A digit is blanked only if it and everything above it is zero, it is not
    // digit 0, and it is not at or below a visible decimal point.
    always_comb begin
        logic w_zero_hi;
        w_blank  = '0;
        w_dp_sel = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_zero_hi = 1'b1;
            for (int j = i; j < NUM_DIGITS; j++)
                if (w_digits[j*4 +: 4] != 4'd0)
                    w_zero_hi = 1'b0;
            w_blank[i]  = (i != 0) && w_zero_hi &&
                          !((r_dp <= 3'd5) && (3'(i) <= r_dp));
            w_dp_sel[i] = (r_dp == 3'(i));
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_enc
        seg7_encode u_enc (
            .i_nibble (w_digits[g*4 +: 4]),
            .i_blank  (w_blank[g]),
            .i_dash   (r_ovf_pend),
            .i_dp     (w_dp_sel[g]),
            .o_code   (w_code[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_bcd      <= '0;
            r_bin      <= '0;
            r_cnt      <= '0;
            r_dp       <= 3'd7;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++)
                r_seg[i] <= SEG_BLANK;
`ifdef SEG_HEX_MODE_EN
            r_hex      <= 1'b0;
            r_hex_val  <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_load) begin
                        r_bin      <= i_bin_in;
                        r_dp       <= i_dp_pos;
                        r_ovf_pend <= w_ovf_cap;
                        r_bcd      <= '0;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SHIFT;
`ifdef SEG_HEX_MODE_EN
                        r_hex      <= i_hex_mode;
                        r_hex_val  <= w_bin_ext[BCD_W-1:0];
`endif
                    end
                end
                ST_SHIFT: begin
                    r_bcd <= {w_bcd_adj[BCD_W-2:0], r_bin[BIN_W-1]};
                    r_bin <= r_bin << 1;
                    if (r_cnt == CNT_LAST)
                        r_state <= ST_ENCODE;
                    else
                        r_cnt <= r_cnt + CNT_W'(1);
                end
                ST_ENCODE: begin
                    for (int i = 0; i < NUM_DIGITS; i++)
                        r_seg[i] <= w_code[i];
                    r_overflow <= r_ovf_pend;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_overflow   = r_overflow;
    assign o_seg_data_0 = r_seg[0];
    assign o_seg_data_1 = r_seg[1];
    assign o_seg_data_2 = r_seg[2];
    assign o_seg_data_3 = r_seg[3];
    assign o_seg_data_4 = r_seg[4];
    assign o_seg_data_5 = r_seg[5];

endmodule

// File: tb/tb_seg_bin_to_digits.sv
// Self-checking bench for seg_bin_to_digits: directed cases plus random values against a decimal/hex model.
module tb_seg_bin_to_digits;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_load = 1'b0;
    logic [19:0] i_bin_in = '0;
    logic [2:0]  i_dp_pos = 3'd7;
`ifdef SEG_HEX_MODE_EN
    logic        i_hex_mode = 1'b0;
`endif
    logic        o_busy, o_done, o_overflow;
    logic [7:0]  o_seg_data_0, o_seg_data_1, o_seg_data_2;
    logic [7:0]  o_seg_data_3, o_seg_data_4, o_seg_data_5;
    logic [47:0] segs;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    logic [7:0] dig_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg_bin_to_digits #(.BIN_W(20), .MAX_VAL(999999)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (i_load),
        .i_bin_in     (i_bin_in),
        .i_dp_pos     (i_dp_pos),
`ifdef SEG_HEX_MODE_EN
        .i_hex_mode   (i_hex_mode),
`endif
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_overflow   (o_overflow),
        .o_seg_data_0 (o_seg_data_0),
        .o_seg_data_1 (o_seg_data_1),
        .o_seg_data_2 (o_seg_data_2),
        .o_seg_data_3 (o_seg_data_3),
        .o_seg_data_4 (o_seg_data_4),
        .o_seg_data_5 (o_seg_data_5)
    );

    assign segs = {o_seg_data_5, o_seg_data_4, o_seg_data_3,
                   o_seg_data_2, o_seg_data_1, o_seg_data_0};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Display model: split the value into decimal (or hex) digits arithmetically,
    // then apply the blanking and decimal-point rules digit by digit.
    function automatic logic [47:0] model_segs(input int unsigned v, input int dp, input bit hex);
        int unsigned d [6];
        int unsigned div;
        int msd;
        logic [7:0] c;
        logic [47:0] r;
        if (!hex && v > 999999) return {6{8'hBF}};
        div = 1;
        for (int i = 0; i < 6; i++) begin
            d[i] = hex ? ((v >> (4 * i)) & 32'hF) : ((v / div) % 10);
            div  = div * 10;
        end
        msd = 0;
        for (int i = 0; i < 6; i++)
            if (d[i] != 0) msd = i;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            c = dig_tab[d[i]];
            if (i > msd && !(dp <= 5 && i <= dp)) c = 8'hFF;
            if (dp == i) c = c & 8'h7F;
            r[i*8 +: 8] = c;
        end
        return r;
    endfunction

    task automatic run_conv(input string tag, input int unsigned v, input int dp,
                            input bit hex, input int inject_at);
        int lat, busy_cnt, done_cnt, extra_busy;
        bit seen;
        i_bin_in = v[19:0];
        i_dp_pos = 3'(dp);
`ifdef SEG_HEX_MODE_EN
        i_hex_mode = hex;
`endif
        i_load = 1'b1;
        tick();
        i_load = 1'b0;
        busy_cnt = o_busy ? 1 : 0;
        lat = 0;
        done_cnt = 0;
        seen = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            if (c == inject_at) begin
                i_load   = 1'b1;
                i_bin_in = 20'd42;
            end
            tick();
            i_load = 1'b0;
            if (o_busy) busy_cnt++;
            if (o_done) begin
                done_cnt++;
                lat  = c;
                seen = 1'b1;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'd21);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd21);
        check({tag, "_segs"}, 64'(segs), 64'(model_segs(v, dp, hex)));
        check({tag, "_overflow"}, 64'(o_overflow), 64'(!hex && v > 999999));
        if (inject_at > 0) begin
            extra_busy = 0;
            for (int c = 0; c < 30; c++) begin
                tick();
                if (o_done) done_cnt++;
                if (o_busy) extra_busy++;
            end
            check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
            check({tag, "_no_restart"}, 64'(extra_busy), 64'd0);
            check({tag, "_segs_hold"}, 64'(segs), 64'(model_segs(v, dp, hex)));
        end
    endtask

    initial begin
        int unsigned rv;
        int rdp, late_done;

        #12;
        check("reset_segs", 64'(segs), {16'h0, {6{8'hFF}}});
        check("reset_busy", 64'(o_busy), 64'd0);
        check("reset_done", 64'(o_done), 64'd0);
        check("reset_overflow", 64'(o_overflow), 64'd0);
        rst_n = 1'b1;
        tick();

        run_conv("full_123456", 123456, 7, 1'b0, -1);
        check("full_literal", 64'(segs), 64'h0000_F9A4_B099_9282);
        run_conv("blank_50", 50, 7, 1'b0, -1);
        check("blank_50_literal", 64'(segs), 64'h0000_FFFF_FFFF_92C0);
        run_conv("dp_5", 5, 2, 1'b0, -1);
        check("dp_5_literal", 64'(segs), 64'h0000_FFFF_FF40_C092);
        run_conv("ovf_1000000", 1000000, 7, 1'b0, -1);
        run_conv("zero_after_ovf", 0, 7, 1'b0, -1);
        run_conv("max_999999", 999999, 0, 1'b0, -1);
        run_conv("dp5_7", 7, 5, 1'b0, -1);
        run_conv("handshake", 999999, 7, 1'b0, 5);

        // Mid-conversion reset: outputs return to reset values at once, no done follows.
        i_bin_in = 20'd777777;
        i_dp_pos = 3'd7;
        i_load   = 1'b1;
        tick();
        i_load = 1'b0;
        for (int c = 0; c < 8; c++) tick();
        rst_n = 1'b0;
        #2;
        check("midrst_segs", 64'(segs), {16'h0, {6{8'hFF}}});
        check("midrst_busy", 64'(o_busy), 64'd0);
        check("midrst_done", 64'(o_done), 64'd0);
        check("midrst_overflow", 64'(o_overflow), 64'd0);
        rst_n = 1'b1;
        late_done = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (o_done) late_done++;
        end
        check("midrst_no_done", 64'(late_done), 64'd0);

        for (int k = 0; k < 20; k++) begin
            rv  = $urandom_range(0, 20'hFFFFF) >> $urandom_range(0, 19);
            rdp = $urandom_range(0, 7);
            run_conv($sformatf("rand%0d", k), rv, rdp, 1'b0, -1);
        end

`ifdef SEG_HEX_MODE_EN
        run_conv("hex_abcde", 20'hABCDE, 7, 1'b1, -1);
        check("hex_literal", 64'(segs), 64'h0000_FF88_83C6_A186);
        run_conv("dec_after_hex", 1000000, 7, 1'b0, -1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seg_bin_to_digits.md
Name: seg_bin_to_digits

Overview:
- Converts a binary count, e.g. a measured frequency, into six 7-segment digit codes.
- Sits directly upstream of the 6-digit scan driver. Outputs feed its seg_data_0..seg_data_5 inputs unchanged.
- Conversion is sequential (shift-add-3, one bit per clock) with a load/busy/done handshake.
- Outputs stay stable between conversions, so the scan driver never shows partial results.

Parameters:
- BIN_W, 20, width of the binary input; legal range 4..32.
- MAX_VAL, 999999, largest value that is displayed; anything larger is an overflow.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- load  in  1  start-conversion strobe; sampled only in IDLE
- bin_in  in  BIN_W  unsigned value; captured on the accepted load edge
- dp_pos  in  3  digit index 0..5 that lights its decimal point; 6 or 7 means no decimal point; captured with bin_in
- busy  out  1  high while a conversion is in progress
- done  out  1  one-cycle pulse in the cycle the new digit codes appear
- overflow  out  1  high when the last captured value was greater than MAX_VAL
- seg_data_0..seg_data_5  out  8 each  digit codes; digit 0 is least significant

Behaviour:
- Clock and reset: clk; reset rst_n, asynchronous, active-low.
- Segment encoding:
  - Active-low: 0 means the segment is lit. bit7 is the decimal point, bits 6:0 are segments g..a.
  - Digit codes 0-9: C0 F9 A4 B0 99 92 82 F8 80 90.
  - Blank is FF. Dash is BF.
- Reset values: all seg_data_n = 8'hFF; busy=0, done=0, overflow=0; state IDLE.
- State machine: IDLE -> SHIFT -> ENCODE -> IDLE.
- IDLE:
  - On load=1, capture bin_in, dp_pos and (bin_in > MAX_VAL) into internal registers.
  - Clear the 24-bit BCD accumulator and bit counter; go to SHIFT; busy=1 from the next cycle.
- SHIFT (exactly BIN_W cycles), each cycle:
  - Add 3 to every BCD nibble that is >= 5.
  - Shift {bcd, bin} left by 1.
  - Leave after the BIN_W-th shift.
- ENCODE (1 cycle):
  - Register all six seg_data outputs, update overflow, pulse done=1, set busy=0.
  - Return to IDLE.
- Latency: load accepted at edge k; outputs and done visible after edge k+BIN_W+1. BIN_W=20 gives 21 cycles. Latency is constant and independent of value or overflow.
- Leading-zero blanking:
  - Blank every digit above the most significant non-zero digit.
  - Digit 0 is never blanked.
  - Digits at or below dp_pos are never blanked, so 5 with dp_pos=2 shows 0.05.
- Decimal point: bit7 is cleared on digit dp_pos only, after blanking is decided.
- Overflow: all six digits show BF (dash); no decimal point; overflow=1 until the next ENCODE.
- load while busy is ignored with no queuing. load asserted in the ENCODE cycle is also ignored.
- seg_data_n and overflow change only in ENCODE.
- Reset mid-conversion immediately returns to reset values; no done pulse.

Optional Feature:
- Macro SEG_HEX_MODE_EN.
- When defined:
  - Adds input port hex_mode (1 bit), captured with bin_in.
  - When hex_mode=1, ENCODE uses the low 24 bits of the captured binary (zero-extended) as six hex nibbles instead of BCD.
  - Hex codes A-F: 88 83 C6 A1 86 8E.
  - overflow is forced 0; blanking and decimal point rules are unchanged; latency is unchanged.
- When not defined: port absent, decimal only.

Decomposition:
- Package seg_pkg holds:
  - segment code constants SEG_BLANK=8'hFF, SEG_DASH=8'hBF, SEG_DP_MASK=8'h7F;
  - the 16-entry digit table;
  - the state encoding (IDLE/SHIFT/ENCODE).
- One sub-module, seg7_encode: combinational nibble plus blank/dp inputs to 8-bit code, instantiated six times.
- The top module keeps the FSM, double-dabble datapath and output registers.

Test Plan:
- Reset: assert rst_n=0 mid-run -> all seg_data=FF, busy=0, done=0, overflow=0.
- Full value: load bin_in=123456, dp_pos=7 -> done exactly 21 cycles later; seg_data_5..0 = F9 A4 B0 99 92 82; busy high for the 20 shift cycles plus the ENCODE-entry cycle only.
- Blanking and decimal point:
  - bin_in=50, dp_pos=7 -> seg_data_0=C0, seg_data_1=92, seg_data_2..5=FF.
  - bin_in=5, dp_pos=2 -> seg_data_0=92, seg_data_1=C0, seg_data_2=40, seg_data_3..5=FF.
- Overflow then recovery: bin_in=1000000 -> all BF, overflow=1; next load of 0 -> seg_data_0=C0, others FF, overflow=0.
- Handshake: second load pulsed 5 cycles after the first (value 999999) -> ignored; outputs reflect the first value; exactly one done pulse.
- SEG_HEX_MODE_EN: hex_mode=1, bin_in=20'hABCDE -> seg_data_0..4 = 86 A1 C6 83 88, seg_data_5=FF, overflow=0.
